// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - runtime-programmable delay line with valid qualifier and in-flight count
module var_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  localparam int DW       = $clog2(MAX_DELAY + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [DW-1:0]    i_delay,
  input  logic             i_delay_load,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_delay,
  output logic [DW-1:0]    o_inflight
);

  // Stage k holds the sample captured k+1 edges ago.
  logic [MAX_DELAY-1:0] valid_q;
  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [DW-1:0]        delay_q;
  logic [DW-1:0]        inflight_q;
  logic [DW-1:0]        delay_next;
  logic                 tap_valid;
  logic [WIDTH-1:0]     tap_data;

  // Clamp the requested delay into 1..MAX_DELAY.
  always_comb begin
    if (i_delay == '0) begin
      delay_next = DW'(1);
    end else if (i_delay > DW'(MAX_DELAY)) begin
      delay_next = DW'(MAX_DELAY);
    end else begin
      delay_next = i_delay;
    end
  end

  // Shift register; a load drops every in-flight sample but keeps the load-cycle capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= {valid_q[MAX_DELAY-2:0] & {(MAX_DELAY-1){~i_delay_load}}, i_valid};
      data_q[0] <= i_data;
      for (int k = 1; k < MAX_DELAY; k++) begin
        data_q[k] <= data_q[k-1];
      end
    end
  end

  // Output tap at stage D-1, selected from registers only.
  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (DW'(k + 1) == delay_q) begin
        tap_valid = valid_q[k];
        tap_data  = data_q[k];
      end
    end
  end

  // Active delay register, updated on load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      delay_q <= DW'(1);
    end else if (i_delay_load) begin
      delay_q <= delay_next;
    end
  end

  // Valid samples inside the active window: entering minus leaving, reseeded on load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= '0;
    end else if (i_delay_load) begin
      inflight_q <= {{(DW-1){1'b0}}, i_valid};
    end else begin
      inflight_q <= inflight_q + {{(DW-1){1'b0}}, i_valid} - {{(DW-1){1'b0}}, tap_valid};
    end
  end

  assign o_valid    = tap_valid;
  assign o_data     = tap_valid ? tap_data : '0;
  assign o_delay    = delay_q;
  assign o_inflight = inflight_q;

endmodule

// File: doc/var_delay_line.md
# var_delay_line

Parametrised, clocked successor to the fixed-delay gate modules used in the timing exercises: a WIDTH-bit data stream with a valid qualifier is delayed by a runtime-programmable number of clock cycles, from 1 to MAX_DELAY. The block sits between a stimulus/data source and a consumer that must see each sample exactly D cycles later. It also reports the number of valid samples currently in flight.

## Interface
- WIDTH, default 8: data width in bits, ≥1.
- MAX_DELAY, default 16: largest selectable delay in cycles, ≥2.
- DW, derived as $clog2(MAX_DELAY+1): width of the delay and count fields. Not for override.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  the sample on i_data is valid this cycle.
- i_data  input  WIDTH  input sample.
- i_delay  input  DW  requested delay, sampled only when i_delay_load=1.
- i_delay_load  input  1  apply i_delay at this edge and flush the line.
- o_valid  output  1  the sample on o_data is valid.
- o_data  output  WIDTH  delayed sample; forced to 0 when o_valid=0.
- o_delay  output  DW  active delay D.
- o_inflight  output  DW  number of valid samples inside the active window.

## Operation
- Storage is a shift register of MAX_DELAY stages, each holding {valid, data}. Stage k holds the input from k+1 cycles earlier.
- Every edge: stage0 ← {i_valid, i_data} and stage[k] ← stage[k-1]. Samples with i_valid=0 still shift, with their valid bit at 0.
- The output tap is stage[D-1]. o_valid = stage[D-1].valid. o_data = stage[D-1].valid ? stage[D-1].data : 0.
- Delay load, when i_delay_load=1 at an edge:
  - D ← clamp(i_delay). Values of 0 or below map to 1; values above MAX_DELAY map to MAX_DELAY.
  - All valid bits in stages 1..MAX_DELAY-1 clear to 0.
  - Stage0 still captures {i_valid, i_data} from the load cycle. That sample therefore emerges after the new D.
  - Samples that were in flight before the load are discarded and never appear at the output.
- In-flight counter:
  - No load: o_inflight ← o_inflight + i_valid − o_valid, with both terms evaluated in the current cycle.
  - Load: o_inflight ← i_valid.
  - The value never exceeds D and never wraps.
- A load with the same D as currently active still flushes.

## Timing
- Reset values: all stage valid bits 0, all stage data 0, D=1, o_valid=0, o_data=0, o_delay=1, o_inflight=0.
- Reset acts asynchronously. Asserting i_rst mid-stream clears everything immediately, without waiting for a clock edge. The first sample accepted after deassertion appears with D=1.
- Latency: a sample presented with i_valid=1 in the cycle before edge n appears on o_valid/o_data in the cycle after edge n+D−1. That is exactly D rising edges after capture.
- Throughput is one sample per cycle with no back-pressure. Gaps in i_valid are reproduced exactly at the output.
- o_delay reflects a load from the edge at which it occurs.
- After a load, o_valid stays 0 for D_new−1 cycles minimum. It is 0 for D_new cycles if the load-cycle i_valid was 0.
- o_valid and o_data depend only on registers, through the tap mux on D. Neither has a combinational path from any input.

## Test plan
- Reset and defaults:
  - Stimulus: assert i_rst between clock edges.
  - Response: o_valid=0, o_data=0, o_delay=1, o_inflight=0 immediately, before the next edge.
  - Stimulus: after release, drive i_valid=1 with i_data=8'hA5 for one cycle.
  - Response: o_data=8'hA5 and o_valid=1 one edge later, then o_valid=0.
- Programmed delay:
  - Stimulus: load i_delay=5, then stream values 1..10 with i_valid=1.
  - Response: 1..10 appear in order with exactly 5 edges of latency, and o_inflight is 5 during steady state.
- Gaps:
  - Stimulus: D=3, pattern valid/invalid/valid with data 8'h11, 8'hFF, 8'h22.
  - Response: output 8'h11, 0 with o_valid=0, then 8'h22, each 3 edges after input.
- Clamp:
  - Stimulus: load i_delay=0.
  - Response: o_delay=1.
  - Stimulus: with MAX_DELAY=16, load i_delay=31.
  - Response: o_delay=16, and a sample emerges 16 edges later.
- Mid-stream reload:
  - Stimulus: D=8 with 6 samples in flight; load i_delay=2 while i_valid=1 with i_data=8'h7E.
  - Response: the old samples never appear, o_inflight=1 after the load edge, and 8'h7E appears 2 edges after the load.
- Reset mid-operation:
  - Stimulus: D=4 with a full window in flight; pulse i_rst asynchronously.
  - Response: outputs return to their reset values at once, and none of the old samples is ever emitted.
